// File: rtl/aes_encrypt_iterative.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional macro AES_LAST_KEY_OUT_EN exposes the round-10 key as last_key_out.

module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);
    // Row-major FIPS-197 S-box; entry 0x00 sits in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX[11'd2047 - {value, 3'b000} -: 8];
endmodule

module aes_encrypt_iterative #(
    parameter bit CLEAR_ON_START = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         encrypt,
    input  logic [127:0] plain_text_in,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
`ifdef AES_LAST_KEY_OUT_EN
    output logic [127:0] last_key_out,
`endif
    output logic [127:0] Dout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]   fsm;
    logic [3:0]   count;
    logic [127:0] state;
    logic [127:0] rkey;
    logic [127:0] sub_out;
    logic [127:0] shift_out;
    logic [127:0] mix_out;
    logic [127:0] next_rkey;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  key_temp;
    logic [7:0]   rcon;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    genvar i, r, c;

    generate
        for (i = 0; i < 16; i++) begin : g_sub_bytes
            aes_sbox u_sbox (
                .value(state[127-8*i -: 8]),
                .subst(sub_out[127-8*i -: 8])
            );
        end

        // Byte index is row + 4*column; row r rotates left by r columns.
        for (r = 0; r < 4; r++) begin : g_shift_row
            for (c = 0; c < 4; c++) begin : g_shift_col
                assign shift_out[127-8*(r+4*c) -: 8] = sub_out[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end

        for (c = 0; c < 4; c++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shift_out[127-32*c -: 8];
            assign a1 = shift_out[119-32*c -: 8];
            assign a2 = shift_out[111-32*c -: 8];
            assign a3 = shift_out[103-32*c -: 8];
            assign mix_out[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mix_out[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mix_out[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mix_out[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        for (i = 0; i < 4; i++) begin : g_sub_word
            aes_sbox u_sbox (
                .value(rot_word[31-8*i -: 8]),
                .subst(sub_word[31-8*i -: 8])
            );
        end
    endgenerate

    assign rot_word = {rkey[23:0], rkey[31:24]};

    // count holds the number of the round being computed, so it selects Rcon directly.
    always_comb begin
        rcon = 8'h00;
        case (count)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign key_temp               = sub_word ^ {rcon, 24'h000000};
    assign next_rkey[127:96]      = rkey[127:96] ^ key_temp;
    assign next_rkey[95:64]       = rkey[95:64] ^ next_rkey[127:96];
    assign next_rkey[63:32]       = rkey[63:32] ^ next_rkey[95:64];
    assign next_rkey[31:0]        = rkey[31:0] ^ next_rkey[63:32];

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm   <= IDLE;
            count <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Dout  <= 128'd0;
            rkey  <= 128'd0;
            state <= 128'd0;
`ifdef AES_LAST_KEY_OUT_EN
            last_key_out <= 128'd0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (encrypt) begin
                        state <= plain_text_in ^ key_in;
                        rkey  <= key_in;
                        count <= 4'd1;
                        busy  <= 1'b1;
                        fsm   <= ROUND;
                        if (CLEAR_ON_START) Dout <= 128'd0;
                    end
                end
                ROUND: begin
                    state <= mix_out ^ next_rkey;
                    rkey  <= next_rkey;
                    count <= count + 4'd1;
                    if (count == 4'd9) fsm <= FINAL;
                end
                FINAL: begin
                    Dout  <= shift_out ^ next_rkey;
                    rkey  <= next_rkey;
`ifdef AES_LAST_KEY_OUT_EN
                    last_key_out <= next_rkey;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    count <= 4'd0;
                    fsm   <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Scoreboard bench for aes_encrypt_iterative using the FIPS-197 vectors.
// Build with AES_LAST_KEY_OUT_EN defined to also check last_key_out.

module tb_aes_encrypt_iterative;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LK1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clock = 1'b0;
    logic         reset;
    logic         encrypt;
    logic [127:0] plain_text_in;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] Dout;
`ifdef AES_LAST_KEY_OUT_EN
    logic [127:0] last_key_out;
`endif

    aes_encrypt_iterative dut (
        .clock(clock),
        .reset(reset),
        .encrypt(encrypt),
        .plain_text_in(plain_text_in),
        .key_in(key_in),
        .busy(busy),
        .done(done),
`ifdef AES_LAST_KEY_OUT_EN
        .last_key_out(last_key_out),
`endif
        .Dout(Dout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] lk;
        int           at;
    } exp_t;

    exp_t sb[$];

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("dout", Dout, e.ct);
                check_output("done_cycle", 128'(cyc), 128'(e.at));
`ifdef AES_LAST_KEY_OUT_EN
                check_output("last_key_out", last_key_out, e.lk);
`endif
            end
        end
    end

    function automatic logic [127:0] garbage();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one request for a single cycle; returns at the negedge after the acceptance edge.
    task automatic apply_stimulus(input logic [127:0] pt, input logic [127:0] key,
                                  input logic [127:0] ct, input logic [127:0] lk,
                                  input bit expect_result);
        exp_t e;
        @(negedge clock);
        encrypt       = 1'b1;
        plain_text_in = pt;
        key_in        = key;
        if (expect_result) begin
            e.ct = ct;
            e.lk = lk;
            e.at = cyc + 11;
            sb.push_back(e);
        end
        @(negedge clock);
        encrypt       = 1'b0;
        plain_text_in = garbage();
        key_in        = garbage();
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && busy === 1'b0) break;
        end
        @(negedge clock);
        check_output(name, 128'(sb.size()), 128'd0);
    endtask

    initial begin
        exp_t e;
        reset         = 1'b1;
        encrypt       = 1'b0;
        plain_text_in = 128'd0;
        key_in        = 128'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("reset_busy", 128'(busy), 128'd0);
        check_output("reset_done", 128'(done), 128'd0);
        check_output("reset_dout", Dout, 128'd0);
`ifdef AES_LAST_KEY_OUT_EN
        check_output("reset_last_key", last_key_out, 128'd0);
`endif

        $display("[TB] test 1: FIPS-197 C.1");
        apply_stimulus(P1, K1, C1, LK1, 1'b1);
        check_output("busy_after_accept", 128'(busy), 128'd1);
        drain("drain_t1", 30);

        $display("[TB] test 2: FIPS-197 B");
        apply_stimulus(P2, K2, C2, LK2, 1'b1);
        check_output("dout_held_during_run", Dout, C1);
        drain("drain_t2", 30);

        $display("[TB] test 3: encrypt while busy");
        apply_stimulus(P2, K2, C2, LK2, 1'b1);
        repeat (3) @(negedge clock);
        encrypt       = 1'b1;
        plain_text_in = P1;
        key_in        = K1;
        @(negedge clock);
        encrypt = 1'b0;
        check_output("busy_ignored_req", 128'(busy), 128'd1);
        drain("drain_t3", 30);
        repeat (15) @(negedge clock);

        $display("[TB] test 4: reset mid-operation");
        apply_stimulus(P1, K1, C1, LK1, 1'b0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_output("midreset_busy", 128'(busy), 128'd0);
        check_output("midreset_done", 128'(done), 128'd0);
        check_output("midreset_dout", Dout, 128'd0);
        repeat (15) @(negedge clock);
        apply_stimulus(P2, K2, C2, LK2, 1'b1);
        drain("drain_t4", 30);

        $display("[TB] test 4b: reset and encrypt together");
        @(negedge clock);
        reset         = 1'b1;
        encrypt       = 1'b1;
        plain_text_in = P1;
        key_in        = K1;
        @(negedge clock);
        reset   = 1'b0;
        encrypt = 1'b0;
        check_output("reset_wins_busy", 128'(busy), 128'd0);
        repeat (15) @(negedge clock);
        check_output("reset_wins_dout", Dout, 128'd0);

        $display("[TB] test 5: encrypt held high, back-to-back");
        @(negedge clock);
        encrypt       = 1'b1;
        plain_text_in = P1;
        key_in        = K1;
        e.ct = C1;
        e.lk = LK1;
        e.at = cyc + 11;
        sb.push_back(e);
        e.ct = C2;
        e.lk = LK2;
        e.at = cyc + 22;
        sb.push_back(e);
        @(negedge clock);
        plain_text_in = P2;
        key_in        = K2;
        repeat (11) @(negedge clock);
        encrypt       = 1'b0;
        plain_text_in = garbage();
        key_in        = garbage();
        check_output("second_accept_busy", 128'(busy), 128'd1);
        drain("drain_t5", 30);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
